// File: rtl/tc_tile_sched.sv
// rtl/tc_tile_sched.sv - tile scheduler feeding a fixed-latency compute array
module tc_tile_sched #(
   parameter int M       = 16,
   parameter int N       = 16,
   parameter int K       = 16,
   parameter int TILE_M  = 4,
   parameter int TILE_K  = 8,
   parameter int DW_DATA = 8,
   parameter int LAT     = 6
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic                               mode,
   input  logic [M*K*DW_DATA-1:0]             in_a,
   input  logic [K*N*DW_DATA-1:0]             in_b,
   output logic                               busy,
   output logic                               tile_valid,
   input  logic                               tile_ready,
   output logic [TILE_M*TILE_K*DW_DATA-1:0]   tile_a,
   output logic [TILE_K*DW_DATA-1:0]          tile_b,
   output logic                               res_valid,
   output logic [$clog2(M)-1:0]               res_row,
   output logic [$clog2(N)-1:0]               res_col,
   output logic                               res_kfirst,
   output logic                               res_klast,
   output logic                               done
);

   localparam int MT  = M / TILE_M;
   localparam int KT  = K / TILE_K;
   localparam int RW  = $clog2(M);
   localparam int CW  = $clog2(N);
   localparam int KW  = $clog2(K);
   localparam int MTW = (MT > 1) ? $clog2(MT) : 1;
   localparam int KTW = (KT > 1) ? $clog2(KT) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

   state_t               r_state;
   logic                 r_busy;
   logic                 r_tile_valid;
   logic                 r_done;
   logic                 r_mode;
   logic [MTW-1:0]       r_m;
   logic [CW-1:0]        r_n;
   logic [KTW-1:0]       r_k;

   // operand copies: A indexed [row][k], B indexed [column][k]
   logic [DW_DATA-1:0]   r_a [M][K];
   logic [DW_DATA-1:0]   r_b [N][K];

   // latency pipe mirroring the compute array: valid plus tag per stage
   logic                 r_pv   [LAT];
   logic [RW-1:0]        r_prow [LAT];
   logic [CW-1:0]        r_pcol [LAT];
   logic                 r_pkf  [LAT];
   logic                 r_pkl  [LAT];

   logic                 w_accept;
   logic                 w_m_max;
   logic                 w_n_max;
   logic                 w_k_max;
   logic                 w_last;
   logic                 w_pipe_busy;
   logic [RW-1:0]        w_row;
   logic [RW-1:0]        w_arow [TILE_M];
   logic [KW-1:0]        w_kcol [TILE_K];

   assign w_accept = r_tile_valid & tile_ready;
   assign w_m_max  = (r_m == MTW'(MT - 1));
   assign w_n_max  = (r_n == CW'(N - 1));
   assign w_k_max  = (r_k == KTW'(KT - 1));
   assign w_last   = w_m_max & w_n_max & w_k_max;
   assign w_row    = RW'(r_m * TILE_M);

   // element selection for the current tile straight from the operand copies
   for (genvar gj = 0; gj < TILE_K; gj++) begin : g_kcol
      assign w_kcol[gj] = KW'(r_k * TILE_K) + KW'(gj);
      assign tile_b[gj*DW_DATA +: DW_DATA] = r_b[r_n][w_kcol[gj]];
   end

   for (genvar gi = 0; gi < TILE_M; gi++) begin : g_arow
      assign w_arow[gi] = w_row + RW'(gi);
      for (genvar gj = 0; gj < TILE_K; gj++) begin : g_acol
         assign tile_a[(gi*TILE_K+gj)*DW_DATA +: DW_DATA] = r_a[w_arow[gi]][w_kcol[gj]];
      end
   end

   // entries that will still be in flight after this edge (last stage drains now)
   always_comb begin
      w_pipe_busy = 1'b0;
      for (int i = 0; i < LAT - 1; i++) begin
         w_pipe_busy = w_pipe_busy | r_pv[i];
      end
   end

   // capture operands and loop order when a job is launched
   always_ff @(posedge clk) begin
      if (r_state == IDLE && start) begin
         for (int r = 0; r < M; r++) begin
            for (int c = 0; c < K; c++) begin
               r_a[r][c] <= in_a[(r*K+c)*DW_DATA +: DW_DATA];
            end
         end
         for (int n = 0; n < N; n++) begin
            for (int c = 0; c < K; c++) begin
               r_b[n][c] <= in_b[(n*K+c)*DW_DATA +: DW_DATA];
            end
         end
         r_mode <= mode;
      end
   end

   // job FSM with tile counters and registered status outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_busy       <= 1'b0;
         r_tile_valid <= 1'b0;
         r_done       <= 1'b0;
         r_m          <= '0;
         r_n          <= '0;
         r_k          <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= LOAD;
                  r_busy  <= 1'b1;
               end
            end
            LOAD: begin
               r_m          <= '0;
               r_n          <= '0;
               r_k          <= '0;
               r_tile_valid <= 1'b1;
               r_state      <= RUN;
            end
            RUN: begin
               if (w_accept) begin
                  if (w_last) begin
                     r_state      <= DRAIN;
                     r_tile_valid <= 1'b0;
                  end
                  if (!r_mode) begin
                     // n innermost, then m, then k
                     if (!w_n_max) begin
                        r_n <= r_n + 1'b1;
                     end else begin
                        r_n <= '0;
                        if (!w_m_max) begin
                           r_m <= r_m + 1'b1;
                        end else begin
                           r_m <= '0;
                           if (!w_k_max) r_k <= r_k + 1'b1;
                           else          r_k <= '0;
                        end
                     end
                  end else begin
                     // k innermost, then n, then m
                     if (!w_k_max) begin
                        r_k <= r_k + 1'b1;
                     end else begin
                        r_k <= '0;
                        if (!w_n_max) begin
                           r_n <= r_n + 1'b1;
                        end else begin
                           r_n <= '0;
                           if (!w_m_max) r_m <= r_m + 1'b1;
                           else          r_m <= '0;
                        end
                     end
                  end
               end
            end
            DRAIN: begin
               if (!w_pipe_busy) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // latency pipe: shifts every cycle, bubbles carry a zero tag
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < LAT; i++) begin
            r_pv[i]   <= 1'b0;
            r_prow[i] <= '0;
            r_pcol[i] <= '0;
            r_pkf[i]  <= 1'b0;
            r_pkl[i]  <= 1'b0;
         end
      end else begin
         r_pv[0]   <= w_accept;
         r_prow[0] <= w_accept ? w_row : '0;
         r_pcol[0] <= w_accept ? r_n : '0;
         r_pkf[0]  <= w_accept & (r_k == '0);
         r_pkl[0]  <= w_accept & w_k_max;
         for (int i = 1; i < LAT; i++) begin
            r_pv[i]   <= r_pv[i-1];
            r_prow[i] <= r_prow[i-1];
            r_pcol[i] <= r_pcol[i-1];
            r_pkf[i]  <= r_pkf[i-1];
            r_pkl[i]  <= r_pkl[i-1];
         end
      end
   end

   assign busy       = r_busy;
   assign tile_valid = r_tile_valid;
   assign done       = r_done;
   assign res_valid  = r_pv[LAT-1];
   assign res_row    = r_prow[LAT-1];
   assign res_col    = r_pcol[LAT-1];
   assign res_kfirst = r_pkf[LAT-1];
   assign res_klast  = r_pkl[LAT-1];

endmodule
